portal_request_demux: RTL and testbench

PORTAL_REQUEST_DEMUX -- requirements
Module: portal_request_demux

---
 rtl/portal_request_demux.sv | 126 ++++++++++++
 tb/tb_portal_request_demux.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/portal_request_demux.sv
// Portal request demultiplexer: splits a header+payload word stream into per-method enq strobes.
// Optional error counter enabled by defining PORTAL_DEMUX_ERRCNT_EN; otherwise err_count is tied to 0.
module portal_request_demux #(
    parameter int NUM_METHODS = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [31:0]            s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [15:0]            size_method,
    input  logic [15:0]            size_bits,
    output logic [31:0]            req_data,
    output logic [NUM_METHODS-1:0] req_en,
    input  logic [NUM_METHODS-1:0] req_notfull,
    output logic                   err_pulse,
    output logic [15:0]            err_count,
    output logic [1:0]             o_dbg_state
);

    // Handshake: a word moves when s_valid & s_ready are both high at a CLK edge.
    // s_ready depends only on state, the registered method and req_notfull, never on s_valid.
    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_PAY  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [16:0] LP_NUM_METHODS = 17'(NUM_METHODS);

    state_t                   r_state;
    logic [15:0]              r_method;
    logic [15:0]              r_remaining;
    logic                     r_err_pulse;

    logic [15:0]              w_hdr_method;
    logic [15:0]              w_hdr_len;
    logic [16:0]              w_size_sum;
    logic [16:0]              w_words;
    logic                     w_method_ok;
    logic                     w_len_ok;
    logic [NUM_METHODS-1:0]   w_sel;
    logic                     w_sel_notfull;
    logic                     w_xfer;

    assign w_hdr_method = s_data[31:16];
    assign w_hdr_len    = s_data[15:0];

    // Word count is ceil(size_bits/32), with an empty message still occupying one word.
    assign w_size_sum   = {1'b0, size_bits} + 17'd31;
    assign w_words      = (size_bits == 16'd0) ? 17'd1 : (w_size_sum >> 5);
    assign w_method_ok  = ({1'b0, w_hdr_method} < LP_NUM_METHODS);
    assign w_len_ok     = ({1'b0, w_hdr_len} == w_words);

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_METHODS; i++) begin
            w_sel[i] = (r_method == 16'(i));
        end
    end

    assign w_sel_notfull = |(w_sel & req_notfull);
    assign s_ready       = (r_state == ST_PAY) ? w_sel_notfull : 1'b1;
    assign w_xfer        = s_valid & s_ready;

    assign size_method   = (r_state == ST_HDR) ? w_hdr_method : r_method;
    assign req_data      = s_data;
    assign req_en        = (r_state == ST_PAY && w_xfer && !RST) ? w_sel : '0;
    assign err_pulse     = r_err_pulse;
    assign o_dbg_state   = r_state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_HDR;
            r_method    <= 16'd0;
            r_remaining <= 16'd0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            case (r_state)
                ST_HDR: begin
                    if (w_xfer) begin
                        if (w_method_ok && w_len_ok) begin
                            r_method    <= w_hdr_method;
                            r_remaining <= w_words[15:0];
                            r_state     <= ST_PAY;
                        end else begin
                            r_err_pulse <= 1'b1;
                            // A bad header with a nonzero length still owns the following words.
                            if (w_hdr_len != 16'd0) begin
                                r_remaining <= w_hdr_len;
                                r_state     <= ST_DROP;
                            end
                        end
                    end
                end
                ST_PAY, ST_DROP: begin
                    if (w_xfer) begin
                        r_remaining <= r_remaining - 16'd1;
                        if (r_remaining == 16'd1) begin
                            r_state <= ST_HDR;
                        end
                    end
                end
                default: r_state <= ST_HDR;
            endcase
        end
    end

`ifdef PORTAL_DEMUX_ERRCNT_EN
    logic [15:0] r_err_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err_count <= 16'd0;
        end else if (r_err_pulse && r_err_count != 16'hFFFF) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_portal_request_demux.sv
// Bench for portal_request_demux: cycle vectors, reset-mid-message sequence, random stream vs message model.
module tb_portal_request_demux;

    localparam int NM = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic [31:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic [15:0]   size_method;
    logic [15:0]   size_bits;
    logic [31:0]   req_data;
    logic [NM-1:0] req_en;
    logic [NM-1:0] req_notfull;
    logic          err_pulse;
    logic [15:0]   err_count;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad = 0;

    logic [15:0] lut [4];

    always #5 CLK = ~CLK;

    // Downstream messageSize lookup: combinational on size_method.
    assign size_bits = (size_method < 16'd4) ? lut[size_method[1:0]] : 16'd32;

    portal_request_demux #(.NUM_METHODS(NM)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .size_method (size_method),
        .size_bits   (size_bits),
        .req_data    (req_data),
        .req_en      (req_en),
        .req_notfull (req_notfull),
        .err_pulse   (err_pulse),
        .err_count   (err_count),
        .o_dbg_state (dbg_state)
    );

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: records every enq as {method, data} and counts error pulses.
    logic [35:0] got_q [$];
    int          err_seen = 0;

    always @(negedge CLK) begin
        if (RST === 1'b1) begin
            check("req_en_in_reset", 36'(req_en), 36'd0);
        end else if (RST === 1'b0) begin
            if (req_en != '0) begin
                logic [3:0] m;
                m = 4'd0;
                for (int i = 0; i < NM; i++) begin
                    if (req_en[i]) m = 4'(i);
                end
                check("req_en_onehot", 36'($onehot(req_en)), 36'd1);
                check("req_en_needs_xfer", 36'(s_valid & s_ready), 36'd1);
                got_q.push_back({m, req_data});
            end
            if (err_pulse) err_seen++;
        end
    end

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [2:0]  nf;
        logic        rdy;
        logic [2:0]  en;
        logic [31:0] rd;
        logic [1:0]  st;
        logic        err;
        logic [15:0] sm;
    } vec_t;

    vec_t vq [$];

    task automatic add(input logic v, input logic [31:0] d, input logic [2:0] nf, input logic rdy,
                       input logic [2:0] en, input logic [31:0] rd, input logic [1:0] st,
                       input logic err, input logic [15:0] sm);
        vec_t t;
        t.v = v; t.d = d; t.nf = nf; t.rdy = rdy; t.en = en; t.rd = rd; t.st = st; t.err = err; t.sm = sm;
        vq.push_back(t);
    endtask

    function automatic int words_for(input logic [15:0] bits);
        if (bits == 16'd0) return 1;
        return (int'(bits) + 31) / 32;
    endfunction

    localparam logic [1:0] HDR = 2'd0, PAY = 2'd1, DROP = 2'd2;

    logic [31:0] words [$];
    logic [35:0] exp_q [$];
    int          exp_err;
    int          exp_cnt_table;

    initial begin
        RST = 1'b1; s_valid = 1'b0; s_data = 32'd0; req_notfull = 3'b111;
        lut[0] = 16'd32; lut[1] = 16'd32; lut[2] = 16'd8; lut[3] = 16'd32;
`ifdef PORTAL_DEMUX_ERRCNT_EN
        exp_cnt_table = 3;
`else
        exp_cnt_table = 0;
`endif

        // ---- clock/reset ----
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("rst_state", 36'(dbg_state), 36'(HDR));
        check("rst_s_ready", 36'(s_ready), 36'd1);
        check("rst_err_pulse", 36'(err_pulse), 36'd0);
        check("rst_err_count", 36'(err_count), 36'd0);
        check("rst_req_en", 36'(req_en), 36'd0);

        // ---- cycle vectors: v, data, notfull | ready, en, req_data, state, err_pulse, size_method ----
        // single-word method 1
        add(1, 32'h0001_0001, 3'b111, 1, 3'b000, 0, HDR, 0, 16'd1);
        add(1, 32'h1234_5678, 3'b111, 1, 3'b010, 32'h1234_5678, PAY, 0, 16'd1);
        add(0, 32'h0, 3'b111, 1, 3'b000, 0, HDR, 0, 16'd0);
        // back-to-back messages, no bubble
        add(1, 32'h0000_0001, 3'b111, 1, 3'b000, 0, HDR, 0, 16'd0);
        add(1, 32'h0000_0011, 3'b111, 1, 3'b001, 32'h11, PAY, 0, 16'd0);
        add(1, 32'h0001_0001, 3'b111, 1, 3'b000, 0, HDR, 0, 16'd1);
        add(1, 32'h0000_0022, 3'b111, 1, 3'b010, 32'h22, PAY, 0, 16'd1);
        add(0, 32'h0, 3'b111, 1, 3'b000, 0, HDR, 0, 16'd0);
        // method 2 (8 bits -> 1 word) with downstream full for 3 cycles
        add(1, 32'h0002_0001, 3'b111, 1, 3'b000, 0, HDR, 0, 16'd2);
        add(1, 32'h0000_00A5, 3'b011, 0, 3'b000, 0, PAY, 0, 16'd2);
        add(1, 32'h0000_00A5, 3'b011, 0, 3'b000, 0, PAY, 0, 16'd2);
        add(1, 32'h0000_00A5, 3'b011, 0, 3'b000, 0, PAY, 0, 16'd2);
        add(1, 32'h0000_00A5, 3'b111, 1, 3'b100, 32'hA5, PAY, 0, 16'd2);
        add(0, 32'h0, 3'b111, 1, 3'b000, 0, HDR, 0, 16'd0);
        // illegal method 5, two dropped words
        add(1, 32'h0005_0002, 3'b111, 1, 3'b000, 0, HDR, 0, 16'd5);
        add(1, 32'hAAAA_0000, 3'b111, 1, 3'b000, 0, DROP, 1, 16'd0);
        add(1, 32'hBBBB_0000, 3'b111, 1, 3'b000, 0, DROP, 0, 16'd0);
        add(0, 32'h0, 3'b111, 1, 3'b000, 0, HDR, 0, 16'd0);
        // length mismatch, three dropped words (one while downstream full), then a good message
        add(1, 32'h0000_0003, 3'b111, 1, 3'b000, 0, HDR, 0, 16'd0);
        add(1, 32'h0000_0001, 3'b111, 1, 3'b000, 0, DROP, 1, 16'd0);
        add(1, 32'h0000_0002, 3'b000, 1, 3'b000, 0, DROP, 0, 16'd0);
        add(1, 32'h0000_0003, 3'b111, 1, 3'b000, 0, DROP, 0, 16'd0);
        add(1, 32'h0000_0001, 3'b111, 1, 3'b000, 0, HDR, 0, 16'd0);
        add(1, 32'h0000_0077, 3'b111, 1, 3'b001, 32'h77, PAY, 0, 16'd0);
        add(0, 32'h0, 3'b111, 1, 3'b000, 0, HDR, 0, 16'd0);
        // bad header with zero length stays in HDR
        add(1, 32'h0007_0000, 3'b111, 1, 3'b000, 0, HDR, 0, 16'd7);
        add(1, 32'h0000_0001, 3'b111, 1, 3'b000, 0, HDR, 1, 16'd0);
        add(1, 32'h0000_0099, 3'b111, 1, 3'b001, 32'h99, PAY, 0, 16'd0);
        add(0, 32'h0, 3'b111, 1, 3'b000, 0, HDR, 0, 16'd0);

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge CLK);
            #1;
            s_valid = vq[i].v; s_data = vq[i].d; req_notfull = vq[i].nf;
            @(negedge CLK);
            check($sformatf("v%0d s_ready", i), 36'(s_ready), 36'(vq[i].rdy));
            check($sformatf("v%0d req_en", i), 36'(req_en), 36'(vq[i].en));
            if (vq[i].en != 3'b000) check($sformatf("v%0d req_data", i), 36'(req_data), 36'(vq[i].rd));
            check($sformatf("v%0d state", i), 36'(dbg_state), 36'(vq[i].st));
            check($sformatf("v%0d err_pulse", i), 36'(err_pulse), 36'(vq[i].err));
            if (vq[i].st != DROP) check($sformatf("v%0d size_method", i), 36'(size_method), 36'(vq[i].sm));
        end
        check("table_err_count", 36'(err_count), 36'(exp_cnt_table));

        // ---- reset in the middle of a message ----
        @(posedge CLK);
        #1 s_valid = 1'b1; s_data = 32'h0001_0001; req_notfull = 3'b111;
        @(negedge CLK);
        check("midrst_hdr_state", 36'(dbg_state), 36'(HDR));
        @(posedge CLK);
        #1 RST = 1'b1; s_data = 32'hDEAD_BEEF;
        @(negedge CLK);
        check("midrst_in_pay", 36'(dbg_state), 36'(PAY));
        check("midrst_no_en", 36'(req_en), 36'd0);
        @(posedge CLK);
        #1 RST = 1'b0; s_data = 32'h0000_0001;
        @(negedge CLK);
        check("midrst_state_hdr", 36'(dbg_state), 36'(HDR));
        check("midrst_err_count", 36'(err_count), 36'd0);
        @(posedge CLK);
        #1 s_data = 32'hDEAD_BEEF;
        @(negedge CLK);
        check("midrst_req_en", 36'(req_en), 36'b001);
        check("midrst_req_data", 36'(req_data), 36'(32'hDEAD_BEEF));
        @(posedge CLK);
        #1 s_valid = 1'b0;
        @(negedge CLK);
        check("midrst_back_hdr", 36'(dbg_state), 36'(HDR));

        // ---- random stream against a message-level model ----
        lut[0] = 16'd64; lut[1] = 16'd0; lut[2] = 16'd100; lut[3] = 16'd40;
        got_q.delete();
        err_seen = 0;
        exp_err = 0;
        for (int n = 0; n < 120; n++) begin
            int m, wm, l;
            logic ok;
            m  = $urandom_range(0, 4);
            wm = (m < NM) ? words_for(lut[m]) : 1;
            l  = ($urandom_range(0, 3) != 0) ? wm : $urandom_range(0, 5);
            ok = (m < NM) && (l == wm);
            words.push_back({16'(m), 16'(l)});
            for (int k = 0; k < l; k++) begin
                logic [31:0] d;
                d = $urandom;
                words.push_back(d);
                if (ok) exp_q.push_back({4'(m), d});
            end
            if (!ok) exp_err++;
        end

        begin
            int idx, cycles;
            idx = 0;
            cycles = 0;
            while (idx < words.size() && cycles < 5000) begin
                @(posedge CLK);
                #1;
                for (int b = 0; b < NM; b++) req_notfull[b] = ($urandom_range(0, 3) != 0);
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = words[idx];
                @(negedge CLK);
                if (s_valid && s_ready) idx++;
                cycles++;
            end
            check("rand_words_accepted", 36'(idx), 36'(words.size()));
        end
        @(posedge CLK);
        #1 s_valid = 1'b0; req_notfull = 3'b111;
        repeat (4) @(negedge CLK);

        check("rand_enq_count", 36'(got_q.size()), 36'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("rand_enq%0d", i), got_q[i], exp_q[i]);
        end
        check("rand_err_pulses", 36'(err_seen), 36'(exp_err));
`ifdef PORTAL_DEMUX_ERRCNT_EN
        check("rand_err_count", 36'(err_count), 36'(exp_err));
`else
        check("rand_err_count", 36'(err_count), 36'd0);
`endif
        check("rand_end_state", 36'(dbg_state), 36'(HDR));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
